// File: rtl/ntt_bf_pipe_ctrl.sv
// Butterfly pipeline controller for the NTT/INTT engine: issues coefficient and zeta reads,
// delays each descriptor to its write-back slot, and tracks drain, commit count and RAW hazards.
module ntt_bf_pipe_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned ZETA_W = 7,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned BF_LAT = 4,
   parameter int unsigned CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr_up,
   input  logic [ADDR_W-1:0] i_addr_dn,
   input  logic [ZETA_W-1:0] i_zeta_idx,
   input  logic              i_last_stage,
   input  logic              i_sel,
   input  logic              i_gen_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr_a,
   output logic [ADDR_W-1:0] o_rd_addr_b,
   output logic [ZETA_W-1:0] o_zeta_addr,
   output logic              o_bf_mode,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr_a,
   output logic [ADDR_W-1:0] o_wr_addr_b,
   output logic              o_scale_en,
   output logic              o_busy,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_bf_count,
   output logic              o_hazard
);

   localparam int unsigned D = RD_LAT + BF_LAT;

   // Read issue stage
   logic              rd_v_q, rd_v_d;
   logic [ADDR_W-1:0] rd_up_q, rd_up_d;
   logic [ADDR_W-1:0] rd_dn_q, rd_dn_d;
   logic [ZETA_W-1:0] rd_zeta_q, rd_zeta_d;
   logic              rd_last_q, rd_last_d;
   logic              rd_sel_q, rd_sel_d;

   // Delay line, entry 0 youngest, entry D-1 is the write-back slot
   logic [D-1:0]      dl_v_q, dl_v_d;
   logic [D-1:0]      dl_last_q, dl_last_d;
   logic [D-1:0]      dl_sel_q, dl_sel_d;
   logic [ADDR_W-1:0] dl_up_q [D];
   logic [ADDR_W-1:0] dl_up_d [D];
   logic [ADDR_W-1:0] dl_dn_q [D];
   logic [ADDR_W-1:0] dl_dn_d [D];

   // Completion and status
   logic              pend_q, pend_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              haz_q, haz_d;
   logic              haz_hit;

   always_comb begin
      rd_v_d    = i_valid;
      rd_up_d   = rd_up_q;
      rd_dn_d   = rd_dn_q;
      rd_zeta_d = rd_zeta_q;
      rd_last_d = rd_last_q;
      rd_sel_d  = rd_sel_q;
      if (i_valid) begin
         rd_up_d   = i_addr_up;
         rd_dn_d   = i_addr_dn;
         rd_zeta_d = i_zeta_idx;
         rd_last_d = i_last_stage;
         rd_sel_d  = i_sel;
      end
   end

   always_comb begin
      dl_v_d    = {dl_v_q[D-2:0], rd_v_q};
      dl_last_d = {dl_last_q[D-2:0], rd_last_q};
      dl_sel_d  = {dl_sel_q[D-2:0], rd_sel_q};
      dl_up_d[0] = rd_up_q;
      dl_dn_d[0] = rd_dn_q;
      for (int i = 1; i < D; i++) begin
         dl_up_d[i] = dl_up_q[i-1];
         dl_dn_d[i] = dl_dn_q[i-1];
      end
   end

   // The write-back slot still counts as pending: its write lands at the end of this cycle.
   always_comb begin
      haz_hit = 1'b0;
      for (int i = 0; i < D; i++) begin
         if (dl_v_q[i] &&
             (rd_up_q == dl_up_q[i] || rd_up_q == dl_dn_q[i] ||
              rd_dn_q == dl_up_q[i] || rd_dn_q == dl_dn_q[i])) begin
            haz_hit = 1'b1;
         end
      end
      haz_d = haz_q | (rd_v_q & haz_hit);
   end

   always_comb begin
      done_d = pend_q & ~rd_v_q & ~(|dl_v_q) & ~i_valid;
      pend_d = done_d ? 1'b0 : (pend_q | i_gen_done);
      cnt_d  = cnt_q;
      if (done_q) begin
         cnt_d = '0;
      end else if (dl_v_q[D-1]) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v_q    <= 1'b0;
         rd_up_q   <= '0;
         rd_dn_q   <= '0;
         rd_zeta_q <= '0;
         rd_last_q <= 1'b0;
         rd_sel_q  <= 1'b0;
         dl_v_q    <= '0;
         dl_last_q <= '0;
         dl_sel_q  <= '0;
         for (int i = 0; i < D; i++) begin
            dl_up_q[i] <= '0;
            dl_dn_q[i] <= '0;
         end
         pend_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         haz_q  <= 1'b0;
      end else begin
         rd_v_q    <= rd_v_d;
         rd_up_q   <= rd_up_d;
         rd_dn_q   <= rd_dn_d;
         rd_zeta_q <= rd_zeta_d;
         rd_last_q <= rd_last_d;
         rd_sel_q  <= rd_sel_d;
         dl_v_q    <= dl_v_d;
         dl_last_q <= dl_last_d;
         dl_sel_q  <= dl_sel_d;
         for (int i = 0; i < D; i++) begin
            dl_up_q[i] <= dl_up_d[i];
            dl_dn_q[i] <= dl_dn_d[i];
         end
         pend_q <= pend_d;
         done_q <= done_d;
         cnt_q  <= cnt_d;
         haz_q  <= haz_d;
      end
   end

   assign o_rd_en     = rd_v_q;
   assign o_rd_addr_a = rd_up_q;
   assign o_rd_addr_b = rd_dn_q;
   assign o_zeta_addr = rd_zeta_q;
   assign o_bf_mode   = dl_sel_q[RD_LAT-1];
   assign o_wr_en     = dl_v_q[D-1];
   assign o_wr_addr_a = dl_up_q[D-1];
   assign o_wr_addr_b = dl_dn_q[D-1];
   assign o_scale_en  = dl_v_q[D-1] & dl_sel_q[D-1] & dl_last_q[D-1];
   assign o_busy      = rd_v_q | (|dl_v_q) | pend_q;
   assign o_done      = done_q;
   assign o_bf_count  = cnt_q;
   assign o_hazard    = haz_q;

endmodule

// File: tb/tb_ntt_bf_pipe_ctrl.sv
// Directed self-checking bench for ntt_bf_pipe_ctrl at default parameters (D = 5).
module tb_ntt_bf_pipe_ctrl;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned ZETA_W = 7;
   localparam int unsigned CNT_W  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_valid = 1'b0;
   logic [ADDR_W-1:0] i_addr_up = '0;
   logic [ADDR_W-1:0] i_addr_dn = '0;
   logic [ZETA_W-1:0] i_zeta_idx = '0;
   logic              i_last_stage = 1'b0;
   logic              i_sel = 1'b0;
   logic              i_gen_done = 1'b0;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr_a;
   logic [ADDR_W-1:0] o_rd_addr_b;
   logic [ZETA_W-1:0] o_zeta_addr;
   logic              o_bf_mode;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr_a;
   logic [ADDR_W-1:0] o_wr_addr_b;
   logic              o_scale_en;
   logic              o_busy;
   logic              o_done;
   logic [CNT_W-1:0]  o_bf_count;
   logic              o_hazard;

   int total = 0;
   int bad   = 0;

   // Event tallies taken on the falling edge
   int wr_cnt = 0;
   int scale_cnt = 0;
   int done_cnt = 0;
   int last_unscaled = -1;

   ntt_bf_pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_addr_up    (i_addr_up),
      .i_addr_dn    (i_addr_dn),
      .i_zeta_idx   (i_zeta_idx),
      .i_last_stage (i_last_stage),
      .i_sel        (i_sel),
      .i_gen_done   (i_gen_done),
      .o_rd_en      (o_rd_en),
      .o_rd_addr_a  (o_rd_addr_a),
      .o_rd_addr_b  (o_rd_addr_b),
      .o_zeta_addr  (o_zeta_addr),
      .o_bf_mode    (o_bf_mode),
      .o_wr_en      (o_wr_en),
      .o_wr_addr_a  (o_wr_addr_a),
      .o_wr_addr_b  (o_wr_addr_b),
      .o_scale_en   (o_scale_en),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_bf_count   (o_bf_count),
      .o_hazard     (o_hazard)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_wr_en) begin
         if (!o_scale_en) last_unscaled = wr_cnt;
         wr_cnt = wr_cnt + 1;
      end
      if (o_scale_en) scale_cnt = scale_cnt + 1;
      if (o_done) done_cnt = done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] up, input logic [7:0] dn,
                        input logic [6:0] z, input logic last, input logic sel,
                        input logic gd);
      i_valid = v; i_addr_up = up; i_addr_dn = dn; i_zeta_idx = z;
      i_last_stage = last; i_sel = sel; i_gen_done = gd;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Ticks until o_done is seen; n = budget+1 on timeout, prev = count in the cycle before.
   task automatic wait_done(input int budget, output int n, output int prev);
      n = budget + 1;
      prev = -1;
      for (int k = 1; k <= budget; k++) begin
         prev = int'(o_bf_count);
         tick();
         if (o_done) begin
            n = k;
            break;
         end
      end
   endtask

   // Lone i_gen_done with an empty pipe: o_done two edges later, counter cleared after it.
   task automatic flush(input string tag, input int exp_cnt);
      int n, prev;
      drive(1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      chk({tag, "_busy_pend"}, o_busy, 1);
      wait_done(10, n, prev);
      chk({tag, "_done_lat"}, n, 1);
      chk({tag, "_cnt_pre"}, prev, exp_cnt);
      tick();
      chk({tag, "_cnt_clr"}, o_bf_count, 0);
   endtask

   task automatic stream(input int n, input logic sel);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 8'(i % 128), 8'(i % 128 + 128), 7'(i % 128), (i >= n - 128), sel,
               (i == n - 1));
         tick();
      end
      idle();
   endtask

   initial begin
      int n, prev, w0, s0, d0;

      // Reset state
      #2;
      chk("rst_rd_en", o_rd_en, 0);
      chk("rst_wr_en", o_wr_en, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_cnt", o_bf_count, 0);
      chk("rst_haz", o_hazard, 0);
      tick();
      tick();
      rst = 1'b0;

      // Single descriptor: read 1 edge later, write 5 edges after the read
      drive(1'b1, 8'h00, 8'h80, 7'h01, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("s_rd_en", o_rd_en, 1);
      chk("s_rd_a", o_rd_addr_a, 8'h00);
      chk("s_rd_b", o_rd_addr_b, 8'h80);
      chk("s_zeta", o_zeta_addr, 7'h01);
      chk("s_busy", o_busy, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("s_wr_early", o_wr_en, 0);
      end
      tick();
      chk("s_wr_en", o_wr_en, 1);
      chk("s_wr_a", o_wr_addr_a, 8'h00);
      chk("s_wr_b", o_wr_addr_b, 8'h80);
      chk("s_scale", o_scale_en, 0);
      chk("s_rd_hold", o_rd_addr_b, 8'h80);
      tick();
      chk("s_wr_off", o_wr_en, 0);
      chk("s_cnt", o_bf_count, 1);
      chk("s_idle", o_busy, 0);
      flush("s", 1);

      // Mode captured per descriptor; scale only on INTT last stage
      drive(1'b1, 8'h10, 8'h11, 7'h02, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 8'h12, 8'h13, 7'h03, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      chk("m_mode1", o_bf_mode, 1);
      tick();
      chk("m_mode0", o_bf_mode, 0);
      tick();
      tick();
      tick();
      chk("m_wr1", o_wr_en, 1);
      chk("m_wr1_a", o_wr_addr_a, 8'h10);
      chk("m_scale1", o_scale_en, 1);
      tick();
      chk("m_wr2_b", o_wr_addr_b, 8'h13);
      chk("m_scale0", o_scale_en, 0);
      tick();
      chk("m_cnt", o_bf_count, 2);
      flush("m", 2);

      // Overlapping addresses six cycles apart: first write already retired
      drive(1'b1, 8'd5, 8'd6, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      for (int k = 0; k < 5; k++) tick();
      drive(1'b1, 8'd6, 8'd7, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      for (int k = 0; k < 3; k++) tick();
      chk("h_far", o_hazard, 0);
      for (int k = 0; k < 4; k++) tick();
      flush("hf", 2);

      // Overlapping addresses two cycles apart: hazard, sticky
      drive(1'b1, 8'd5, 8'd6, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      drive(1'b1, 8'd6, 8'd7, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("h_pre", o_hazard, 0);
      tick();
      chk("h_set", o_hazard, 1);
      for (int k = 0; k < 10; k++) tick();
      chk("h_sticky", o_hazard, 1);
      flush("hn", 2);

      // Full NTT: done D+2 cycles after the last read issue
      w0 = wr_cnt; s0 = scale_cnt; d0 = done_cnt;
      stream(896, 1'b0);
      chk("ntt_mode", o_bf_mode, 0);
      wait_done(20, n, prev);
      chk("ntt_done_lat", n, 7);
      chk("ntt_cnt_pre", prev, 896);
      chk("ntt_busy", o_busy, 0);
      tick();
      chk("ntt_cnt_clr", o_bf_count, 0);
      tick();
      tick();
      chk("ntt_wr_total", wr_cnt - w0, 896);
      chk("ntt_scale", scale_cnt - s0, 0);
      chk("ntt_done_once", done_cnt - d0, 1);

      // INTT: scaling on the final 128 writes only
      w0 = wr_cnt; s0 = scale_cnt;
      stream(896, 1'b1);
      chk("intt_mode", o_bf_mode, 1);
      wait_done(20, n, prev);
      chk("intt_done_lat", n, 7);
      chk("intt_cnt_pre", prev, 896);
      tick();
      chk("intt_wr_total", wr_cnt - w0, 896);
      chk("intt_scale", scale_cnt - s0, 128);
      chk("intt_last_unscaled", last_unscaled - w0, 767);

      // Descriptor one cycle after i_gen_done defers o_done
      drive(1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'h20, 8'h21, 7'h04, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("late_no_done", o_done, 0);
      wait_done(20, n, prev);
      chk("late_done_lat", n, 7);
      chk("late_cnt_pre", prev, 1);
      tick();
      chk("late_cnt_clr", o_bf_count, 0);

      // Reset with three descriptors in flight
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'(8'h40 + k), 8'(8'h50 + k), 7'h00, 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      rst = 1'b1;
      #1;
      chk("mr_rd_en", o_rd_en, 0);
      chk("mr_rd_a", o_rd_addr_a, 0);
      chk("mr_busy", o_busy, 0);
      chk("mr_haz", o_hazard, 0);
      w0 = wr_cnt;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("mr_no_wr", wr_cnt - w0, 0);
      chk("mr_cnt", o_bf_count, 0);
      chk("mr_idle", o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
